// File: rtl/maze_mem_arbiter.sv
// Maze RAM arbiter: the renderer reads at any time, and two game ports share the
// single-port RAM during blanking. The renderer always pre-empts a pending game issue.
module maze_mem_arbiter #(
    parameter int         MAZE_CELLS = 1200,
    parameter logic [2:0] WALL_CODE  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blank,
    input  logic        vga_rd,
    input  logic [10:0] vga_addr,
    output logic [2:0]  vga_data,
    output logic        vga_valid,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [10:0] p0_addr,
    input  logic [2:0]  p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [2:0]  p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [10:0] p1_addr,
    input  logic [2:0]  p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [2:0]  p1_rdata,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_wdata,
    input  logic [2:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t      state, state_next;
    logic        last;
    logic        sel_p1;
    logic        start;
    logic        cur;
    logic        cur_we;
    logic [10:0] cur_addr;
    logic [2:0]  cur_wdata;
    logic        cur_oor;
    logic        vga_oor_p1;
    logic [2:0]  rd_val;

    function automatic logic out_of_range(input logic [10:0] a);
        return 32'(a) >= 32'(MAZE_CELLS);
    endfunction

    // Round-robin: on contention serve the port that was not served last.
    assign sel_p1 = (p0_req && p1_req) ? ~last : p1_req;
    assign start  = rst && (state == IDLE) && blank && (p0_req || p1_req);
    assign rd_val = cur_oor ? WALL_CODE : mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (!vga_rd) state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        p0_gnt    = start && !sel_p1;
        p1_gnt    = start && sel_p1;
        p0_done   = (state == DONE) && !cur;
        p1_done   = (state == DONE) && cur;
        mem_addr  = 11'd0;
        mem_we    = 1'b0;
        mem_wdata = 3'd0;
        // Renderer owns the port whenever it asks; otherwise an in-range game issue.
        if (rst && vga_rd) begin
            mem_addr = vga_addr;
        end else if ((state == ISSUE) && !cur_oor) begin
            mem_addr  = cur_addr;
            mem_we    = cur_we;
            mem_wdata = cur_we ? cur_wdata : 3'd0;
        end
        vga_data = vga_valid ? (vga_oor_p1 ? WALL_CODE : mem_rdata) : 3'd0;
    end

    // Control state and visible read results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last       <= 1'b1;
            cur        <= 1'b0;
            vga_valid  <= 1'b0;
            vga_oor_p1 <= 1'b0;
            p0_rdata   <= 3'd0;
            p1_rdata   <= 3'd0;
        end else begin
            vga_valid  <= vga_rd;
            vga_oor_p1 <= out_of_range(vga_addr);
            if (start) begin
                last <= sel_p1;
                cur  <= sel_p1;
            end
            if ((state == CAPTURE) && !cur_we) begin
                if (cur) p1_rdata <= rd_val;
                else     p0_rdata <= rd_val;
            end
        end
    end

    // Latched request fields of the granted port.
    always_ff @(posedge clk) begin
        if (start) begin
            cur_we    <= sel_p1 ? p1_we : p0_we;
            cur_addr  <= sel_p1 ? p1_addr : p0_addr;
            cur_wdata <= sel_p1 ? p1_wdata : p0_wdata;
            cur_oor   <= out_of_range(sel_p1 ? p1_addr : p0_addr);
        end
    end

endmodule
